// File: rtl/seg_pattern_encoder.sv
// seg_pattern_encoder: turns a two-digit stream of active-low seven-segment
// patterns (high digit first) back into a 6-bit value. Handshakes on both
// sides, a per-frame error flag and a timeout on an unfinished frame.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   seg_in      segment pattern {a,b,c,d,e,f,g}, active-low
//   seg_valid   seg_in holds a pattern
//   seg_ready   block accepts a pattern this cycle (state decode)
//   value_out   assembled value, 0 when err is set
//   value_valid value_out/err hold a completed frame
//   value_ready consumer accepts the frame
//   err         frame had an illegal pattern or a high digit above 3
//   timeout     one-cycle pulse when an unfinished frame is abandoned
module seg_pattern_encoder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic       seg_ready,
  output logic [5:0] value_out,
  output logic       value_valid,
  input  logic       value_ready,
  output logic       err,
  output logic       timeout
);

  localparam int unsigned NIB_W = 4;
  localparam int unsigned VAL_W = 6;
  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_HIGH = 2'd0,
    S_LOW  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       high, high_d;
  logic             high_err, high_err_d;
  logic [VAL_W-1:0] value_d;
  logic             err_d, valid_d, timeout_d;

  logic             dig_blank, dig_legal;
  logic [NIB_W-1:0] dig_nib;
  logic             frame_err;

  // Pattern lookup: {blank, legal hex digit, nibble}.
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    logic [5:0] r;
    case (seg)
      7'b0000001: r = {2'b01, 4'h0};
      7'b1001111: r = {2'b01, 4'h1};
      7'b0010010: r = {2'b01, 4'h2};
      7'b0000110: r = {2'b01, 4'h3};
      7'b1001100: r = {2'b01, 4'h4};
      7'b0100100: r = {2'b01, 4'h5};
      7'b0100000: r = {2'b01, 4'h6};
      7'b0001111: r = {2'b01, 4'h7};
      7'b0000000: r = {2'b01, 4'h8};
      7'b0000100: r = {2'b01, 4'h9};
      7'b0001000: r = {2'b01, 4'hA};
      7'b1100000: r = {2'b01, 4'hB};
      7'b0110001: r = {2'b01, 4'hC};
      7'b1000010: r = {2'b01, 4'hD};
      7'b0110000: r = {2'b01, 4'hE};
      7'b0111000: r = {2'b01, 4'hF};
      7'b1111111: r = {2'b10, 4'h0};
      default:    r = 6'b000000;
    endcase
    return r;
  endfunction

  assign {dig_blank, dig_legal, dig_nib} = decode_seg(seg_in);

  // Ready is a pure state decode, forced low while reset is held.
  assign seg_ready = (state != S_OUT) && !rst;

  // Next-state and output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    high_d     = high;
    high_err_d = high_err;
    value_d    = value_out;
    err_d      = err;
    valid_d    = value_valid;
    timeout_d  = 1'b0;
    frame_err  = 1'b0;
    case (state)
      S_HIGH: begin
        if (seg_valid) begin
          // Blank decodes as nibble 0, i.e. a leading blank.
          high_d     = dig_nib[1:0];
          high_err_d = !(dig_blank || (dig_legal && (dig_nib[3:2] == 2'b00)));
          cnt_d      = '0;
          state_d    = S_LOW;
        end
      end
      S_LOW: begin
        if (seg_valid) begin
          frame_err = high_err || !dig_legal;
          err_d     = frame_err;
          value_d   = frame_err ? '0 : {high, dig_nib};
          valid_d   = 1'b1;
          state_d   = S_OUT;
        end else if (TO_EN && (cnt == CNT_LAST)) begin
          timeout_d = 1'b1;
          state_d   = S_HIGH;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (value_ready) begin
          valid_d = 1'b0;
          state_d = S_HIGH;
        end
      end
      default: state_d = S_HIGH;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_HIGH;
      cnt         <= '0;
      high        <= '0;
      high_err    <= 1'b0;
      value_out   <= '0;
      err         <= 1'b0;
      value_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      high        <= high_d;
      high_err    <= high_err_d;
      value_out   <= value_d;
      err         <= err_d;
      value_valid <= valid_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: doc/seg_pattern_encoder.md
# seg_pattern_encoder

Receives a stream of active-low seven-segment patterns, two digits per frame (high digit then low digit), maps each pattern back to its hex nibble, and assembles a 6-bit value. It is the inverse of the two-digit 6-bit seven-segment display decoder. It sits between a segment-pattern source (captured display bus, or test stimulus) and any logic that consumes the numeric value. Ready/valid handshakes on both sides, per-frame error flag, and a timeout on an incomplete frame.

## Interface
- TIMEOUT, 255: cycles allowed between accepting the high digit and accepting the low digit; 0 disables the timeout.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment pattern {a,b,c,d,e,f,g}, bit 6 = a, bit 0 = g, active-low (0 = lit).
- seg_valid  in  1  seg_in holds a valid pattern.
- seg_ready  out  1  block accepts a pattern this cycle.
- value_out  out  6  assembled value; 0 when err set.
- value_valid  out  1  value_out/err hold a completed frame.
- value_ready  in  1  consumer accepts the frame.
- err  out  1  frame contained an illegal pattern or a high digit > 3; qualified by value_valid.
- timeout  out  1  one-cycle pulse when an incomplete frame is abandoned.

## Operation
- Pattern map (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000, blank=1111111.
- Any other pattern is illegal.
- High digit: 0–3 gives value bits [5:4]; blank is treated as 0 (leading blank); 4–F or illegal sets err.
- Low digit: 0–F gives value bits [3:0]; blank or illegal sets err.
- FSM states:
  - S_HIGH: seg_ready=1; on transfer, register high nibble and high error, clear timeout counter, go to S_LOW.
  - S_LOW: seg_ready=1; on transfer, register value_out = {high[1:0], low[3:0]} (or 0 on any error) and err, then go to S_OUT. Without a transfer, the counter increments; when TIMEOUT≠0 and the counter reaches TIMEOUT-1, go to S_HIGH and pulse timeout.
  - S_OUT: seg_ready=0, value_valid=1; value_out and err are held stable; on value_ready, go to S_HIGH.
- Transfer means seg_valid && seg_ready at a rising edge; seg_valid is ignored when seg_ready=0.
- Error does not abort a frame: both digits are always consumed.

## Timing
- Reset (asynchronous, immediate): state S_HIGH, counter 0, value_out=0, value_valid=0, err=0, timeout=0. seg_ready=0 while rst is high and 1 from the first cycle after release.
- seg_ready is a combinational decode of the state only; it does not depend on seg_valid.
- value_valid rises the cycle after the low-digit transfer.
- Minimum frame period is 3 cycles: high transfer, low transfer, output cycle with value_ready=1.
- value_valid falls the cycle after the edge where value_ready=1. value_ready is ignored outside S_OUT.
- Timeout: if the high digit is accepted at edge N and no low transfer follows, timeout pulses and the state is S_HIGH after edge N+TIMEOUT. A low transfer at that same edge wins: no timeout, and the frame completes.
- The timeout pulse is registered and lasts exactly one cycle. It does not assert value_valid or err.
- Reset mid-frame or in S_OUT discards the partial or pending frame with no output.

## Test plan
- Reset release, then high=0000110 (3), low=0000100 (9), value_ready=1 → value_out=0x39 (57), err=0, value_valid high for 1 cycle, seg_ready low during S_OUT.
- High=1111111 (blank), low=1100000 (b) → value_out=0x0B, err=0; high=1001100 (4), low=0000001 → value_out=0, err=1.
- Illegal low pattern 1010101 after high=1001111 → err=1, value_out=0; the next frame decodes normally.
- value_ready held low 10 cycles → value_out/err stable, seg_ready=0, seg_valid pulses ignored; release → value_valid drops the next cycle.
- TIMEOUT=4: high accepted, no low for 4 cycles → timeout pulse, back in S_HIGH, no value_valid; repeat with low at the 4th edge → value completes, no timeout.
- Assert rst asynchronously in S_LOW and in S_OUT → all outputs 0 immediately; the next frame decodes correctly.
